// File: rtl/i2s_sample_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sample_rx_if
// Description : Serial I2S input pins and parallel sample/status outputs of
//               the I2S receiver. The master drives the wire, and the slave
//               is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_sample_rx_if #(
  parameter int WIDTH = 14
) ();
  logic             i2s_dat;
  logic             i2s_lrck;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             pair_stb;
  logic             locked;
  logic             frame_err;

  modport master (
    output i2s_dat, i2s_lrck,
    input  left, right, pair_stb, locked, frame_err
  );

  modport slave (
    input  i2s_dat, i2s_lrck,
    output left, right, pair_stb, locked, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/i2s_sample_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sample_rx
// Description : I2S receiver. It deserialises an MSB-first stream into left and
//               right samples, checks the half-frame length and reports lock.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_rx #(
  parameter int WIDTH    = 14,
  parameter int DELAY    = 2,
  parameter int HALF_LEN = 128
) (
  input  wire logic       i2s_clk,
  input  wire logic       rst,
  i2s_sample_rx_if.slave  bus
);

  localparam int c_POS_W = $clog2(2 * HALF_LEN);
  localparam logic [c_POS_W-1:0] c_POS_MAX   = c_POS_W'(2 * HALF_LEN - 1);
  localparam logic [c_POS_W-1:0] c_SKIP_END  = c_POS_W'(DELAY - 1);
  localparam logic [c_POS_W-1:0] c_SHIFT_END = c_POS_W'(DELAY + WIDTH - 1);
  localparam logic [c_POS_W-1:0] c_HALF_END  = c_POS_W'(HALF_LEN - 1);

  localparam logic [2:0] c_HUNT  = 3'd0;
  localparam logic [2:0] c_SKIP  = 3'd1;
  localparam logic [2:0] c_SHIFT = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_WAIT  = 3'd4;

  logic               r_dat_q;
  logic               r_lrck_q;
  logic               r_lrck_p;
  logic [c_POS_W-1:0] r_pos;
  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_left;
  logic [WIDTH-1:0]   r_right;
  logic [1:0]         r_good_cnt;
  logic               r_locked;
  logic               r_pair_stb;
  logic               r_frame_err;
  logic               r_left_ok;   // left committed in the half just before this one

  logic w_edge;
  logic w_good_half;

  assign w_edge      = (r_lrck_q != r_lrck_p);
  assign w_good_half = (r_pos == c_HALF_END);

  // Register the pins once, and keep the previous word select for edge detection
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      r_dat_q  <= 1'b0;
      r_lrck_q <= 1'b0;
      r_lrck_p <= 1'b0;
    end else begin
      r_dat_q  <= bus.i2s_dat;
      r_lrck_q <= bus.i2s_lrck;
      r_lrck_p <= r_lrck_q;
    end
  end

  // Bit position within the half-frame, restarted by every word-select edge
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (w_edge) begin
      r_pos <= '0;
    end else if (r_pos != c_POS_MAX) begin
      r_pos <= r_pos + c_POS_W'(1);
    end
  end

  // Capture FSM, commit of samples, and frame-length / lock tracking
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      r_state     <= c_HUNT;
      r_shreg     <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_good_cnt  <= 2'd0;
      r_locked    <= 1'b0;
      r_pair_stb  <= 1'b0;
      r_frame_err <= 1'b0;
      r_left_ok   <= 1'b0;
    end else begin
      r_pair_stb  <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        c_HUNT: begin
          if (w_edge) begin
            r_state <= c_SKIP;
          end
        end
        c_SKIP: begin
          if (r_pos == c_SKIP_END) begin
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_shreg <= {r_shreg[WIDTH-2:0], r_dat_q};
          if (r_pos == c_SHIFT_END) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          // r_lrck_p equals r_lrck_q here unless an edge lands on this very
          // cycle; then it still names the half the word came from.
          if (r_lrck_p) begin
            r_right    <= r_shreg;
            r_pair_stb <= r_locked & r_left_ok;
            r_left_ok  <= 1'b0;
          end else begin
            r_left    <= r_shreg;
            r_left_ok <= 1'b1;
          end
          r_state <= c_WAIT;
        end
        default: begin
          r_state <= c_WAIT;
        end
      endcase

      // Any edge outside HUNT judges the half that just ended and restarts
      // the capture. If a word was still in SKIP/SHIFT, it is dropped.
      if (w_edge && (r_state != c_HUNT)) begin
        r_state <= c_SKIP;
        if (w_good_half) begin
          if (r_good_cnt != 2'd2) begin
            r_good_cnt <= r_good_cnt + 2'd1;
          end
          if (r_good_cnt != 2'd0) begin
            r_locked <= 1'b1;
          end
        end else begin
          r_frame_err <= r_locked;
          r_locked    <= 1'b0;
          r_good_cnt  <= 2'd0;
          r_left_ok   <= 1'b0;
        end
        // A fresh left half means any stored left no longer pairs with a right
        if (!r_lrck_q) begin
          r_left_ok <= 1'b0;
        end
      end
    end
  end

  assign bus.left      = r_left;
  assign bus.right     = r_right;
  assign bus.pair_stb  = r_pair_stb;
  assign bus.locked    = r_locked;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_sample_rx
// Description : Self-checking bench for i2s_sample_rx. An I2S transmitter
//               model drives half-frames, and expected sample pairs are queued
//               and matched against pair_stb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_rx;

  localparam int WIDTH    = 14;
  localparam int DELAY    = 2;
  localparam int HALF_LEN = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_ferr = 0;
  logic carry = 1'b0;   // bit sent on the word-select change: last slot of previous half

  i2s_sample_rx_if #(.WIDTH(WIDTH)) bus ();

  i2s_sample_rx #(
    .WIDTH    (WIDTH),
    .DELAY    (DELAY),
    .HALF_LEN (HALF_LEN)
  ) dut (
    .i2s_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    int               at;
  } pair_t;

  pair_t sb[$];
  pair_t e_pair;

  typedef struct {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    logic             junk;
    logic             exp_pair;
    logic             exp_locked;
  } frame_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic slot_bit(input int s, input logic [WIDTH-1:0] val, input logic junk);
    if (s >= DELAY && s < DELAY + WIDTH) return val[WIDTH-1-(s-DELAY)];
    return junk;
  endfunction

  // Scoreboard: every pair_stb must match the oldest expected pair and its cycle
  always @(negedge clk) begin
    if (bus.pair_stb === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pair_stb: pair_stb=1 at cycle %0d, expected 0", cyc);
      end else begin
        e_pair = sb.pop_front();
        check("pair_left", 32'(bus.left), 32'(e_pair.l));
        check("pair_right", 32'(bus.right), 32'(e_pair.r));
        check("pair_stb_cycle", cyc, e_pair.at);
      end
    end
    if (bus.frame_err === 1'b1) n_ferr++;
  end

  // One half-frame of len clocks. Slot k goes out k+1 clocks after the word-select change.
  task automatic send_half(input logic ch, input int len, input logic [WIDTH-1:0] val,
                           input logic junk, input logic exp_pair,
                           input logic [WIDTH-1:0] exp_left, input int rst_at);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_left", 32'(bus.left), 0);
        check("rst_right", 32'(bus.right), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_pair_stb", 32'(bus.pair_stb), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
      end
      bus.i2s_lrck = ch;
      if (c == 0) begin
        bus.i2s_dat = carry;
      end else begin
        bus.i2s_dat = slot_bit(c - 1, val, junk);
        if (exp_pair && (c - 1 == DELAY + WIDTH - 1))
          sb.push_back('{l: exp_left, r: val, at: cyc + 3});
      end
      rst = (c == rst_at);
    end
    carry = slot_bit(len - 1, val, junk);
  endtask

  frame_t tbl[7];

  initial begin
    tbl[0] = '{14'h2A5C, 14'h2A5C, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{14'h2A5C, 14'h2A5C, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{14'h2A5C, 14'h2A5C, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{14'h2A5C, 14'h2A5C, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{14'h3FFF, 14'h0001, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{14'h0000, 14'h2000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{14'h1555, 14'h1555, 1'b1, 1'b1, 1'b1};

    bus.i2s_dat  = 1'b0;
    bus.i2s_lrck = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_left", 32'(bus.left), 0);
    check("reset_right", 32'(bus.right), 0);
    check("reset_pair_stb", 32'(bus.pair_stb), 0);
    check("reset_locked", 32'(bus.locked), 0);
    check("reset_frame_err", 32'(bus.frame_err), 0);
    rst = 1'b0;

    // Short preamble half gives the receiver its first edge and leaves HUNT.
    // Its length is bad, and the receiver is not locked, so no frame_err is expected.
    send_half(1'b1, 40, '0, 1'b0, 1'b0, '0, -1);

    // Table: lock-up, channel separation, and padding with junk bits
    for (int i = 0; i < 7; i++) begin
      send_half(1'b0, HALF_LEN, tbl[i].l, tbl[i].junk, 1'b0, '0, -1);
      send_half(1'b1, HALF_LEN, tbl[i].r, tbl[i].junk, tbl[i].exp_pair, tbl[i].l, -1);
      check($sformatf("frame%0d_locked", i), 32'(bus.locked), 32'(tbl[i].exp_locked));
      check($sformatf("frame%0d_left", i), 32'(bus.left), 32'(tbl[i].l));
      check($sformatf("frame%0d_right", i), 32'(bus.right), 32'(tbl[i].r));
    end
    check("table_frame_err_count", n_ferr, 0);

    // Short left half: the word-select edge arrives at pos 100 while locked
    send_half(1'b0, 101, 14'h0ABC, 1'b0, 1'b0, '0, -1);
    send_half(1'b1, HALF_LEN, 14'h1234, 1'b0, 1'b0, '0, -1);
    check("short_frame_err_count", n_ferr, 1);
    check("short_locked", 32'(bus.locked), 0);
    check("short_right", 32'(bus.right), 32'(14'h1234));
    send_half(1'b0, HALF_LEN, 14'h3C3C, 1'b0, 1'b0, '0, -1);
    check("relock_one_good_half", 32'(bus.locked), 0);
    send_half(1'b1, HALF_LEN, 14'h03C3, 1'b0, 1'b1, 14'h3C3C, -1);
    check("relock_locked", 32'(bus.locked), 1);

    // One-clock reset in the middle of a left word
    send_half(1'b0, HALF_LEN, 14'h1111, 1'b0, 1'b0, '0, 8);
    send_half(1'b1, HALF_LEN, 14'h2222, 1'b0, 1'b0, '0, -1);
    check("after_rst_left", 32'(bus.left), 0);
    check("after_rst_right", 32'(bus.right), 32'(14'h2222));
    check("after_rst_locked", 32'(bus.locked), 0);
    send_half(1'b0, HALF_LEN, 14'h0F0F, 1'b0, 1'b0, '0, -1);
    send_half(1'b1, HALF_LEN, 14'h30F0, 1'b0, 1'b1, 14'h0F0F, -1);
    check("after_rst_relock", 32'(bus.locked), 1);

    // Word select held for 600 clocks: the position counter saturates quietly
    send_half(1'b0, 600, 14'h2468, 1'b0, 1'b0, '0, -1);
    check("hold_frame_err_count", n_ferr, 1);
    check("hold_left", 32'(bus.left), 32'(14'h2468));
    check("hold_locked", 32'(bus.locked), 1);
    send_half(1'b1, HALF_LEN, 14'h1357, 1'b0, 1'b0, '0, -1);
    check("post_hold_frame_err_count", n_ferr, 2);
    check("post_hold_locked", 32'(bus.locked), 0);
    check("post_hold_right", 32'(bus.right), 32'(14'h1357));

    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
